wb_arbiter: RTL

- Round-robin Wishbone bus arbiter that shares one wb_slave between NUM_MASTERS requesting masters.
- Sits between the masters and the slave's adr_i/dat_i/dat_o/we_i/cyc_i/stb_i/ack_o port set.
- Grants the bus per cycle (cyc) and holds the grant until the owner drops cyc.
- A watchdog terminates stalled cycles with an error pulse.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_rr_picker.sv | 39 +++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone arbitration definitions.
//
// Contents:
//   WB_ADDR_WIDTH / WB_DATA_WIDTH : default bus widths for the current build.
//   arb_state_t                   : arbiter FSM states.
//   rr_next()                     : round-robin candidate index.
package wb_pkg;

    localparam int WB_ADDR_WIDTH = 8;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index of the candidate examined at position 'offset' of a scan.
    // The scan starts just after the last owner and wraps modulo 'n'.
    function automatic int unsigned rr_next(input int unsigned last,
                                            input int unsigned offset,
                                            input int unsigned n);
        return (last + 1 + offset) % n;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
//
// Scans the request vector starting one position after the last owner and
// returns the first requester found as a one-hot grant.
//
// Ports:
//   req_i   : request vector, one bit per requester.
//   last_i  : index of the previous owner.
//   grant_o : one-hot winner, zero when nothing requests.
//   valid_o : high when grant_o holds a winner.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] &&
                    rr_next(int'(last_i), k, N) == j) begin
                    grant_o[j] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave between NUM_MASTERS masters.
//
// A master wins the bus by raising cyc and keeps it until it drops cyc.
// There is no preemption. A watchdog ends stalled strobes with a one-cycle
// error pulse to the owner.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset.
//   m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_i : per-master request signals
//                       (packed, master k at slice k).
//   m_dat_o           : slave read data, broadcast to all masters.
//   m_ack_o / m_err_o : per-master acknowledge / watchdog error.
//   s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o : to the slave.
//   s_dat_i / s_ack_i : from the slave.
//   grant_o           : one-hot current owner, zero when idle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] WDOG_LIMIT = CW'(TIMEOUT);

    arb_state_t             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          last_q;
    logic [CW-1:0]          wdog_q;
    logic [CW-1:0]          wdog_d;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;

    logic owner_cyc;
    logic owner_stb;
    logic stb_raw;
    logic expire;

    wb_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_grant[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    // grant_q is non-zero only in BUSY, so these also cover the idle case.
    // Dropping the owner's cyc drops s_cyc_o in the same cycle.
    assign owner_cyc = |(grant_q & m_cyc_i);
    assign owner_stb = |(grant_q & m_stb_i);
    assign stb_raw   = owner_cyc & owner_stb;

    // wdog_q holds the number of stalled strobe cycles seen so far; once
    // TIMEOUT of them have passed the current cycle is cut short. A
    // same-cycle ack takes priority over the timeout.
    assign expire = stb_raw && !s_ack_i && (wdog_q == WDOG_LIMIT);

    assign s_cyc_o = owner_cyc;
    assign s_stb_o = stb_raw && !expire;
    assign s_we_o  = owner_cyc && |(grant_q & m_we_i);
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    // Gating with owner_cyc keeps a late ack away from a master that has
    // already released the bus.
    assign m_ack_o = grant_q & {NUM_MASTERS{owner_cyc && s_ack_i}};
    assign m_err_o = grant_q & {NUM_MASTERS{expire}};

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i] && owner_cyc) begin
                s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Forced-low strobe on expiry, a low strobe, an ack or leaving BUSY all
    // clear the counter.
    assign wdog_d = (s_stb_o && !s_ack_i) ? wdog_q + 1'b1 : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RESET;
            wdog_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_grant;
                        owner_q <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // No re-arbitration here: one idle cycle separates owners.
                    if (!owner_cyc) begin
                        last_q  <= owner_q;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
